// File: rtl/regfile_write_scheduler_if.sv
// Writeback bus bundle for regfile_write_scheduler.
// Holds the ALU and load request channels, the issue channel that marks a
// register as pending, and the registered register-file write port plus the
// busy scoreboard. The master modport is the environment; the slave modport
// is the scheduler itself.
interface regfile_write_scheduler_if;
  logic        alu_valid;
  logic [2:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        alu_ready;

  logic        mem_valid;
  logic [2:0]  mem_wa;
  logic [31:0] mem_wd;
  logic        mem_ready;

  logic        iss_valid;
  logic [2:0]  iss_wa;

  logic        rf_we;
  logic [2:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [7:0]  busy;

  modport master (
    output alu_valid, alu_wa, alu_wd,
    output mem_valid, mem_wa, mem_wd,
    output iss_valid, iss_wa,
    input  alu_ready, mem_ready,
    input  rf_we, rf_wa, rf_wd, busy
  );

  modport slave (
    input  alu_valid, alu_wa, alu_wd,
    input  mem_valid, mem_wa, mem_wd,
    input  iss_valid, iss_wa,
    output alu_ready, mem_ready,
    output rf_we, rf_wa, rf_wd, busy
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
// Merges ALU and load writebacks onto a single register-file write port and
// keeps a busy scoreboard of registers that have a write outstanding.
// Build option: define WSCHED_RR_EN for round-robin arbitration between the
// two requesters; leave it undefined for fixed load (MEM) priority.
module regfile_write_scheduler #(
  parameter int NREG = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  regfile_write_scheduler_if.slave  wif
);

  // Only scoreboard bits that name a real architectural register may ever be set.
  localparam logic [7:0] VALID_MASK = (NREG >= 8) ? 8'hFF : 8'((1 << NREG) - 1);

  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_MEM = 1'b1
  } arb_state_t;

  arb_state_t  r_state;
  arb_state_t  w_stateNext;

  logic        w_aluGrant;
  logic        w_memGrant;
  logic        w_xfer;
  logic [2:0]  w_winWa;
  logic [31:0] w_winWd;

  logic        r_rfWe;
  logic [2:0]  r_rfWa;
  logic [31:0] r_rfWd;
  logic [7:0]  r_busy;

  logic [7:0]  w_setMask;
  logic [7:0]  w_clrMask;
  logic [7:0]  w_busyNext;

  // Arbiter state register; reset leaves it at LAST_MEM so the first conflict favours the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LAST_MEM;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Grant decision and next arbiter state; grants are forced low while reset is held.
  always_comb begin
    w_aluGrant  = 1'b0;
    w_memGrant  = 1'b0;
    w_stateNext = r_state;
    if (!rst) begin
      if (wif.alu_valid && wif.mem_valid) begin
`ifdef WSCHED_RR_EN
        if (r_state == LAST_MEM) begin
          w_aluGrant = 1'b1;
        end else begin
          w_memGrant = 1'b1;
        end
`else
        w_memGrant = 1'b1;
`endif
      end else if (wif.alu_valid) begin
        w_aluGrant = 1'b1;
      end else if (wif.mem_valid) begin
        w_memGrant = 1'b1;
      end
    end
    if (w_aluGrant) begin
      w_stateNext = LAST_ALU;
    end else if (w_memGrant) begin
      w_stateNext = LAST_MEM;
    end
  end

  assign w_xfer  = w_aluGrant | w_memGrant;
  assign w_winWa = w_aluGrant ? wif.alu_wa : wif.mem_wa;
  assign w_winWd = w_aluGrant ? wif.alu_wd : wif.mem_wd;

  // Scoreboard update: clear the bit being written back, then apply the issue set so a same-bit set wins.
  always_comb begin
    w_setMask = 8'h00;
    w_clrMask = 8'h00;
    if (w_xfer) begin
      w_clrMask[w_winWa] = 1'b1;
    end
    if (wif.iss_valid) begin
      w_setMask[wif.iss_wa] = 1'b1;
    end
    w_busyNext = ((r_busy & ~w_clrMask) | w_setMask) & VALID_MASK;
  end

  // Output write port: a transfer loads the winner, an idle edge drops the enable and holds address/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rfWe <= 1'b0;
      r_rfWa <= 3'd0;
      r_rfWd <= 32'd0;
    end else if (w_xfer) begin
      r_rfWe <= 1'b1;
      r_rfWa <= w_winWa;
      r_rfWd <= w_winWd;
    end else begin
      r_rfWe <= 1'b0;
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 8'h00;
    end else begin
      r_busy <= w_busyNext;
    end
  end

  assign wif.alu_ready = w_aluGrant;
  assign wif.mem_ready = w_memGrant;
  assign wif.rf_we     = r_rfWe;
  assign wif.rf_wa     = r_rfWa;
  assign wif.rf_wd     = r_rfWd;
  assign wif.busy      = r_busy;

endmodule

// File: doc/regfile_write_scheduler.md
REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

Interface
REQ-001 The block SHALL have the parameter NREG, default 8, meaning the number of architectural registers; the register address width is fixed at 3.
REQ-002 The block SHALL have the port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst  in  1  the reset, asynchronous and active-high.
REQ-004 The block SHALL have the port alu_valid  in  1  ALU writeback request.
REQ-005 The block SHALL have the port alu_wa  in  3  ALU destination register.
REQ-006 The block SHALL have the port alu_wd  in  32  ALU result.
REQ-007 The block SHALL have the port alu_ready  out  1  ALU request granted this cycle (combinational).
REQ-008 The block SHALL have the port mem_valid  in  1  load writeback request.
REQ-009 The block SHALL have the port mem_wa  in  3  load destination register.
REQ-010 The block SHALL have the port mem_wd  in  32  load data.
REQ-011 The block SHALL have the port mem_ready  out  1  load request granted this cycle (combinational).
REQ-012 The block SHALL have the port iss_valid  in  1  an instruction issues with a pending register write.
REQ-013 The block SHALL have the port iss_wa  in  3  destination register of the issuing instruction.
REQ-014 The block SHALL have the port rf_we  out  1  register-file write enable (registered).
REQ-015 The block SHALL have the port rf_wa  out  3  register-file write address (registered).
REQ-016 The block SHALL have the port rf_wd  out  32  register-file write data (registered).
REQ-017 The block SHALL have the port busy  out  8  scoreboard; bit n set means register n has a write pending (registered).

Function
REQ-018 A transfer SHALL occur on a requester when its valid and ready are both high at a rising clk edge.
REQ-019 At most one of alu_ready and mem_ready SHALL be high in any cycle.
REQ-020 ready SHALL depend only on the valids and the arbiter state, never on the requester's own ready.
REQ-021 A requester SHALL hold valid, wa and wd stable until its transfer completes; the block does not need to tolerate withdrawal.
REQ-022 If exactly one valid is high, that requester SHALL be granted in the same cycle.
REQ-023 If both valids are high, the winner SHALL follow the arbitration policy in REQ-035 and REQ-036.
REQ-024 The arbiter SHALL be a two-state FSM, LAST_ALU and LAST_MEM.
REQ-025 The FSM SHALL move to LAST_ALU on an ALU transfer and to LAST_MEM on a MEM transfer.
REQ-026 The FSM SHALL hold its state when no transfer occurs.
REQ-027 Latency SHALL be one cycle: the edge that completes a transfer loads rf_we=1 and the winning wa and wd into rf_wa and rf_wd.
REQ-028 The edge with no transfer SHALL load rf_we=0 and hold rf_wa and rf_wd.
REQ-029 Throughput SHALL be one write per cycle with no bubbles.
REQ-030 The issue edge SHALL set busy[iss_wa] when iss_valid is high.
REQ-031 The edge on which rf_we becomes 1 SHALL clear busy[wa] for the winning wa.
REQ-032 If a set and a clear target the same bit on the same edge, set SHALL win and the bit stays 1.
REQ-033 Sets and clears to different bits on the same edge SHALL both take effect.
REQ-034 A clear of a bit that is already 0 SHALL leave it 0, with no error flag.

Reset
REQ-035 (Arbitration, RR mode) When WSCHED_RR_EN is defined, a two-way conflict SHALL grant the requester not named by the FSM state, i.e. alternate winners.
REQ-036 (Arbitration, fixed mode) When WSCHED_RR_EN is undefined, a conflict SHALL always grant MEM; the FSM is still kept but does not affect the grant.
REQ-037 While rst is high, the following SHALL hold immediately and independent of clk: rf_we=0, rf_wa=0, rf_wd=0, busy=8'h00, and FSM=LAST_MEM.
REQ-038 alu_ready and mem_ready SHALL be 0 while rst is high.
REQ-039 An assertion of rst mid-stream SHALL discard any write captured in the output register and clear all pending bits.
REQ-040 The first conflict after rst deasserts SHALL go to ALU in RR mode.

Configuration
REQ-041 The macro WSCHED_RR_EN SHALL select the arbitration policy: defined gives round-robin per REQ-035, undefined gives fixed MEM priority per REQ-036.
REQ-042 Changing WSCHED_RR_EN SHALL change no port and no other behaviour.

Verification
REQ-043 After rst, a single ALU request (wa=3, wd=32'haaaaaaaa) SHALL give alu_ready=1 in the same cycle, then next cycle rf_we=1, rf_wa=3, rf_wd=32'haaaaaaaa, then rf_we=0.
REQ-044 With both valids held high for 4 cycles (ALU wa=4 wd=32'h55555555, MEM wa=5 wd=32'h12345678) and each requester reissuing after its transfer, RR mode SHALL write 4,5,4,5 and fixed mode SHALL write 5,5,5,5 with ALU starved.
REQ-045 With iss_valid=1 and iss_wa=6, busy SHALL read 8'h40 on the next cycle; a MEM write to register 6 SHALL then return busy to 8'h00 on the edge where rf_we=1.
REQ-046 With busy[2]=1, a write to register 2 and an issue to register 2 on the same edge SHALL leave busy[2]=1; a write to register 1 together with an issue to register 7 SHALL make busy[1]=0 and busy[7]=1.
REQ-047 Asserting rst asynchronously between edges while rf_we=1 and busy=8'hff SHALL force rf_we=0, busy=8'h00 and both ready outputs to 0 before the next edge.
REQ-048 With no valids high for 3 cycles, rf_we SHALL stay 0 and rf_wa/rf_wd SHALL hold their last values.
